uio_prbs_port: RTL and testbench



---
 rtl/uio_prbs_port.sv | 244 ++++++++++++++++++++++++
 tb/tb_uio_prbs_port.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_prbs_port.sv
// PRBS31 traffic generator and loopback checker for one Aurora user-I/O port.
// Requests go out on uio_rq_*, returned words on uio_rs_* are checked; CSR window gives control and stats.
module uio_prbs_port #(
  parameter int          UIO_PORTS_WIDTH = 128,
  parameter logic [15:0] CSR_BASE        = 16'h0100,
  parameter int          DRAIN_TIMEOUT   = 1024
) (
  input  logic                       clk_per,
  input  logic                       reset_per_n,
  input  logic [15:0]                i_csr_addr,
  input  logic [63:0]                i_csr_data,
  input  logic                       i_csr_wr_vld,
  input  logic                       i_csr_rd_vld,
  output logic [63:0]                o_csr_data,
  output logic                       o_csr_rd_ack,
  output logic                       uio_rq_vld,
  output logic [UIO_PORTS_WIDTH-1:0] uio_rq_data,
  input  logic                       uio_rq_afull,
  input  logic                       uio_rs_vld,
  input  logic [UIO_PORTS_WIDTH-1:0] uio_rs_data,
  output logic                       uio_rs_afull
);

  localparam int          W          = UIO_PORTS_WIDTH;
  localparam int          IW         = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(DRAIN_TIMEOUT - 1);
  localparam logic [30:0] SEED_ZERO_SUB = 31'h7FFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  typedef struct packed {
    logic [W-1:0] word;
    logic [30:0]  lfsr;
  } prbs_t;

  // One word = next W sequence bits, first generated bit in the MSB.
  function automatic prbs_t prbs_step(input logic [30:0] s);
    prbs_t r;
    logic  b;
    r.lfsr = s;
    r.word = '0;
    for (int i = W - 1; i >= 0; i--) begin
      b         = r.lfsr[30] ^ r.lfsr[27];
      r.word[i] = b;
      r.lfsr    = {r.lfsr[29:0], b};
    end
    return r;
  endfunction

  function automatic logic [47:0] sat_inc(input logic [47:0] v);
    return (&v) ? v : v + 48'd1;
  endfunction

  state_t        state_q, state_d;
  logic [30:0]   gen_q, chk_q, seed_q;
  logic [47:0]   target_q, tx_cnt_q, rx_cnt_q, err_cnt_q, first_idx_q;
  logic [63:0]   first_xor_q;
  logic          err_seen_q, stray_q, timeout_q, inject_q;
  logic [IW-1:0] idle_q;

  // CSR decode: aligned 64-bit registers inside the 8-entry window only.
  logic [15:0] csr_off;
  logic        csr_hit, wr_hit, rd_hit, ctrl_wr;
  logic [2:0]  csr_idx;
  logic        cmd_clear, cmd_start, cmd_stop, cmd_inject;
  logic        unused_bits;

  assign csr_off    = i_csr_addr - CSR_BASE;
  assign csr_hit    = (i_csr_addr >= CSR_BASE) && (csr_off[15:6] == 10'd0) && (csr_off[2:0] == 3'd0);
  assign csr_idx    = csr_off[5:3];
  assign wr_hit     = i_csr_wr_vld && csr_hit;
  assign rd_hit     = i_csr_rd_vld && csr_hit;
  assign ctrl_wr    = wr_hit && (csr_idx == 3'd0);
  assign cmd_clear  = ctrl_wr && i_csr_data[2];
  assign cmd_start  = ctrl_wr && i_csr_data[0] && !i_csr_data[2];
  assign cmd_stop   = ctrl_wr && i_csr_data[1] && !i_csr_data[0] && !i_csr_data[2];
  assign cmd_inject = ctrl_wr && i_csr_data[3] && !i_csr_data[2];
  assign unused_bits = &{1'b0, i_csr_data[63:48]};

  prbs_t         gen_step, chk_step;
  logic [30:0]   seed_eff;
  logic          rs_accept, rs_stray, rs_mismatch;
  logic [W-1:0]  rs_diff;
  logic [W+63:0] rs_diff_ext;
  logic [47:0]   tx_inc, rx_next;

  assign gen_step    = prbs_step(gen_q);
  assign chk_step    = prbs_step(chk_q);
  assign seed_eff    = (seed_q == 31'd0) ? SEED_ZERO_SUB : seed_q;
  assign rs_accept   = uio_rs_vld && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign rs_stray    = uio_rs_vld && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign rs_diff     = uio_rs_data ^ chk_step.word;
  assign rs_diff_ext = {64'd0, rs_diff};
  assign rs_mismatch = |rs_diff;
  assign tx_inc      = sat_inc(tx_cnt_q);
  assign rx_next     = rs_accept ? sat_inc(rx_cnt_q) : rx_cnt_q;
  assign uio_rs_afull = 1'b0;

  logic emit, load, zero, timeout_hit;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    emit        = 1'b0;
    load        = 1'b0;
    zero        = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (cmd_clear) begin
          zero    = 1'b1;
          state_d = S_IDLE;
        end else if (cmd_start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cmd_clear) begin
          zero    = 1'b1;
          state_d = S_IDLE;
        end else begin
          emit = !uio_rq_afull;
          if (cmd_stop || (emit && (target_q != 48'd0) && (tx_inc == target_q)))
            state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cmd_clear) begin
          zero    = 1'b1;
          state_d = S_IDLE;
        end else if (rx_next == tx_cnt_q) begin
          state_d = S_DONE;
        end else if (!uio_rs_vld && (idle_q == IDLE_LIMIT)) begin
          timeout_hit = 1'b1;
          state_d     = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [63:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    unique case (csr_idx)
      3'd0: rd_mux = {56'd0, timeout_q, stray_q, err_seen_q, 2'b00, state_q};
      3'd1: rd_mux = {33'd0, seed_q};
      3'd2: rd_mux = {16'd0, target_q};
      3'd3: rd_mux = {16'd0, tx_cnt_q};
      3'd4: rd_mux = {16'd0, rx_cnt_q};
      3'd5: rd_mux = {16'd0, err_cnt_q};
      3'd6: rd_mux = {16'd0, first_idx_q};
      default: rd_mux = first_xor_q;
    endcase
  end

  always_ff @(posedge clk_per) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!reset_per_n) begin
      state_q <= S_IDLE;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= ((state_q == S_DRAIN) && !uio_rs_vld) ? idle_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk_per) begin
    if (!reset_per_n) begin
      o_csr_data   <= '0;
      o_csr_rd_ack <= 1'b0;
      uio_rq_vld   <= 1'b0;
      uio_rq_data  <= '0;
      gen_q        <= '0;
      chk_q        <= '0;
      seed_q       <= 31'd1;
      target_q     <= '0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_xor_q  <= '0;
      err_seen_q   <= 1'b0;
      stray_q      <= 1'b0;
      timeout_q    <= 1'b0;
      inject_q     <= 1'b0;
    end else begin
      o_csr_rd_ack <= rd_hit;
      if (rd_hit) o_csr_data <= rd_mux;
      if (wr_hit && (csr_idx == 3'd1)) seed_q   <= i_csr_data[30:0];
      if (wr_hit && (csr_idx == 3'd2)) target_q <= i_csr_data[47:0];

      uio_rq_vld <= emit;
      if (emit) begin
        uio_rq_data <= gen_step.word ^ {{(W-1){1'b0}}, inject_q};
        gen_q       <= gen_step.lfsr;
      end

      // Inject survives start; clear drops it, emission consumes it.
      if (zero)            inject_q <= 1'b0;
      else if (cmd_inject) inject_q <= 1'b1;
      else if (emit)       inject_q <= 1'b0;

      if (load || zero) begin
        if (load) begin
          gen_q <= seed_eff;
          chk_q <= seed_eff;
        end
        tx_cnt_q    <= '0;
        rx_cnt_q    <= '0;
        err_cnt_q   <= '0;
        first_idx_q <= '0;
        first_xor_q <= '0;
        err_seen_q  <= 1'b0;
        stray_q     <= 1'b0;
        timeout_q   <= 1'b0;
      end else begin
        if (emit) tx_cnt_q <= tx_inc;
        if (rs_accept) begin
          rx_cnt_q <= rx_next;
          chk_q    <= chk_step.lfsr;
          if (rs_mismatch) begin
            err_cnt_q  <= sat_inc(err_cnt_q);
            err_seen_q <= 1'b1;
            if (err_cnt_q == 48'd0) begin
              first_idx_q <= rx_cnt_q;
              first_xor_q <= rs_diff_ext[63:0];
            end
          end
        end
        if (rs_stray)    stray_q   <= 1'b1;
        if (timeout_hit) timeout_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uio_prbs_port.sv
// Scoreboard bench for uio_prbs_port: stimulus pushes expected request words and CSR read
// data into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_uio_prbs_port;

  localparam int          W    = 128;
  localparam logic [15:0] BASE = 16'h0100;
  localparam logic [15:0] A_CTRL = BASE + 16'h00, A_SEED = BASE + 16'h08, A_TGT = BASE + 16'h10;
  localparam logic [15:0] A_TX   = BASE + 16'h18, A_RX   = BASE + 16'h20, A_ERR = BASE + 16'h28;
  localparam logic [15:0] A_IDX  = BASE + 16'h30, A_XOR  = BASE + 16'h38;
  localparam logic [63:0] ALL = '1;

  logic          clk_per = 1'b0;
  logic          reset_per_n;
  logic [15:0]   i_csr_addr;
  logic [63:0]   i_csr_data;
  logic          i_csr_wr_vld, i_csr_rd_vld;
  logic [63:0]   o_csr_data;
  logic          o_csr_rd_ack;
  logic          uio_rq_vld;
  logic [W-1:0]  uio_rq_data;
  logic          uio_rq_afull;
  logic          uio_rs_vld;
  logic [W-1:0]  uio_rs_data;
  logic          uio_rs_afull;

  always #5 clk_per = ~clk_per;

  uio_prbs_port #(.UIO_PORTS_WIDTH(W), .CSR_BASE(BASE), .DRAIN_TIMEOUT(1024)) dut (
    .clk_per(clk_per), .reset_per_n(reset_per_n),
    .i_csr_addr(i_csr_addr), .i_csr_data(i_csr_data),
    .i_csr_wr_vld(i_csr_wr_vld), .i_csr_rd_vld(i_csr_rd_vld),
    .o_csr_data(o_csr_data), .o_csr_rd_ack(o_csr_rd_ack),
    .uio_rq_vld(uio_rq_vld), .uio_rq_data(uio_rq_data), .uio_rq_afull(uio_rq_afull),
    .uio_rs_vld(uio_rs_vld), .uio_rs_data(uio_rs_data), .uio_rs_afull(uio_rs_afull)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Golden PRBS31: x[n] = x[n-31] ^ x[n-28], seed bits are x[-31] (bit 30) .. x[-1] (bit 0).
  logic [W-1:0] mw[$];
  task automatic model_gen(input logic [30:0] seed, input int n);
    bit           b[$];
    bit           nb;
    logic [W-1:0] word;
    mw.delete();
    for (int i = 30; i >= 0; i--) b.push_back(seed[i]);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < W; k++) begin
        nb = b[b.size() - 31] ^ b[b.size() - 28];
        b.push_back(nb);
        word[W - 1 - k] = nb;
      end
      mw.push_back(word);
    end
  endtask

  // Scoreboard queues
  logic [W-1:0] exp_rq[$];
  logic [63:0]  exp_rd[$];
  logic [63:0]  exp_rd_mask[$];
  string        exp_rd_name[$];
  int           rq_seen = 0;
  logic         afull_prev = 1'b0;

  always @(negedge clk_per) begin
    if (reset_per_n === 1'b1) begin
      if (afull_prev) check("afull_gap_vld", uio_rq_vld, 0);
      if (uio_rq_vld) begin
        rq_seen++;
        if (exp_rq.size() == 0) check("rq_unexpected", uio_rq_vld, 0);
        else check($sformatf("rq_word_%0d", rq_seen), uio_rq_data, exp_rq.pop_front());
      end
      if (o_csr_rd_ack) begin
        if (exp_rd.size() == 0) check("rd_unexpected", o_csr_rd_ack, 0);
        else begin
          logic [63:0] m;
          m = exp_rd_mask.pop_front();
          check(exp_rd_name.pop_front(), o_csr_data & m, exp_rd.pop_front() & m);
        end
      end
    end
    afull_prev = uio_rq_afull;
  end

  // One-cycle loopback with an optional dropped word (absolute word index).
  bit lb_en   = 1'b0;
  int lb_drop = -1;
  int lb_idx  = 0;
  initial begin
    logic         cv;
    logic [W-1:0] cd;
    uio_rs_vld  = 1'b0;
    uio_rs_data = '0;
    forever begin
      @(negedge clk_per);
      cv = lb_en && uio_rq_vld;
      cd = uio_rq_data;
      if (cv) begin
        if (lb_idx == lb_drop) cv = 1'b0;
        lb_idx++;
      end
      @(posedge clk_per);
      #1;
      uio_rs_vld  = cv;
      uio_rs_data = cd;
    end
  end

  task automatic tick();
    @(posedge clk_per);
    #1;
  endtask

  task automatic csr_write(input logic [15:0] a, input logic [63:0] d);
    i_csr_addr = a; i_csr_data = d; i_csr_wr_vld = 1'b1;
    tick();
    i_csr_wr_vld = 1'b0;
  endtask

  task automatic csr_read(input logic [15:0] a, input logic [63:0] e, input logic [63:0] m, input string n);
    exp_rd.push_back(e); exp_rd_mask.push_back(m); exp_rd_name.push_back(n);
    i_csr_addr = a; i_csr_rd_vld = 1'b1;
    tick();
    i_csr_rd_vld = 1'b0;
  endtask

  task automatic csr_rw(input logic [15:0] a, input logic [63:0] wd, input logic [63:0] e, input string n);
    exp_rd.push_back(e); exp_rd_mask.push_back(ALL); exp_rd_name.push_back(n);
    i_csr_addr = a; i_csr_data = wd; i_csr_rd_vld = 1'b1; i_csr_wr_vld = 1'b1;
    tick();
    i_csr_rd_vld = 1'b0; i_csr_wr_vld = 1'b0;
  endtask

  task automatic csr_probe(input logic [15:0] a, input string n);
    i_csr_addr = a; i_csr_rd_vld = 1'b1;
    tick();
    i_csr_rd_vld = 1'b0;
    @(negedge clk_per);
    check(n, o_csr_rd_ack, 0);
    tick();
  endtask

  task automatic push_model(input bit flip0);
    for (int i = 0; i < mw.size(); i++) exp_rq.push_back((i == 0 && flip0) ? mw[i] ^ 1 : mw[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nw, exp_err;
    logic [63:0] exp_xor;
    reset_per_n = 1'b0; i_csr_addr = '0; i_csr_data = '0;
    i_csr_wr_vld = 1'b0; i_csr_rd_vld = 1'b0; uio_rq_afull = 1'b0;
    repeat (3) tick();
    @(negedge clk_per);
    check("rst_rq_vld", uio_rq_vld, 0);
    check("rst_rq_data", uio_rq_data, 0);
    check("rst_rs_afull", uio_rs_afull, 0);
    check("rst_rd_ack", o_csr_rd_ack, 0);
    check("rst_csr_data", o_csr_data, 0);
    tick();
    reset_per_n = 1'b1;
    tick();

    csr_read(A_CTRL, 64'h0, ALL, "rst_ctrl");
    csr_read(A_SEED, 64'h1, ALL, "rst_seed");
    csr_read(A_TX,   64'h0, ALL, "rst_tx_cnt");
    csr_write(A_TGT, 64'h1234_5678_9ABC);
    csr_read(A_TGT, 64'h1234_5678_9ABC, ALL, "target_readback");
    csr_rw(A_TGT, 64'd16, 64'h1234_5678_9ABC, "target_rw_old");
    csr_read(A_TGT, 64'd16, ALL, "target_new");
    csr_probe(16'h0140, "noack_0140");
    csr_probe(16'h00F8, "noack_00f8");

    // Basic run: seed 1, 16 words.
    lb_en = 1'b1;
    model_gen(31'd1, 16);
    push_model(1'b0);
    csr_write(A_CTRL, 64'h1);
    tick();
    @(negedge clk_per);
    check("seed1_word0_top", uio_rq_data[W-1 -: 32], 32'h0000_0012);
    repeat (17) tick();
    csr_read(A_CTRL, 64'h03, ALL, "run_ctrl_done");
    csr_read(A_TX, 64'd16, ALL, "run_tx_cnt");
    csr_read(A_RX, 64'd16, ALL, "run_rx_cnt");
    csr_read(A_ERR, 64'd0, ALL, "run_err_cnt");
    check("run_all_words_sent", exp_rq.size(), 0);

    // Inject then start: word 0 bit 0 flipped, one error at index 0.
    push_model(1'b1);
    csr_write(A_CTRL, 64'h8);
    csr_write(A_CTRL, 64'h1);
    repeat (19) tick();
    csr_read(A_ERR, 64'd1, ALL, "inj_err_cnt");
    csr_read(A_IDX, 64'd0, ALL, "inj_first_idx");
    csr_read(A_XOR, 64'h1, ALL, "inj_first_xor");
    csr_read(A_CTRL, 64'h23, ALL, "inj_ctrl");
    check("inj_all_words_sent", exp_rq.size(), 0);

    // Run until stop with afull high for relative cycles 5..14.
    csr_write(A_TGT, 64'd0);
    model_gen(31'd1, 64);
    push_model(1'b0);
    base = rq_seen;
    csr_write(A_CTRL, 64'h1);
    for (int c = 1; c < 40; c++) begin
      uio_rq_afull = (c >= 5 && c <= 14);
      tick();
    end
    uio_rq_afull = 1'b0;
    csr_write(A_CTRL, 64'h2);
    repeat (10) tick();
    nw = rq_seen - base;
    check("stop_word_count", nw, 30);
    csr_read(A_TX, 64'(nw), ALL, "stop_tx_cnt");
    csr_read(A_RX, 64'(nw), ALL, "stop_rx_cnt");
    csr_read(A_ERR, 64'd0, ALL, "stop_err_cnt");
    csr_read(A_CTRL, 64'h03, ALL, "stop_ctrl");
    exp_rq.delete();

    // TARGET=8 with word 3 dropped by the loopback: drain timeout.
    csr_write(A_TGT, 64'd8);
    model_gen(31'd1, 8);
    push_model(1'b0);
    exp_err = 0;
    for (int i = 3; i < 7; i++) if (mw[i + 1] != mw[i]) exp_err++;
    exp_xor = 64'(mw[4] ^ mw[3]);
    lb_drop = lb_idx + 3;
    csr_write(A_CTRL, 64'h1);
    repeat (1100) tick();
    csr_read(A_RX, 64'd7, ALL, "tmo_rx_cnt");
    csr_read(A_ERR, 64'(exp_err), ALL, "tmo_err_cnt");
    csr_read(A_IDX, 64'd3, ALL, "tmo_first_idx");
    csr_read(A_XOR, exp_xor, ALL, "tmo_first_xor");
    csr_read(A_CTRL, 64'h83, 64'h87, "tmo_ctrl_timeout_state");
    csr_read(A_CTRL, 64'h20, 64'h20, "tmo_ctrl_err_seen");
    lb_drop = -1;

    // Seed 0 substitutes all-ones.
    csr_write(A_SEED, 64'd0);
    csr_write(A_TGT, 64'd1);
    model_gen(31'h7FFF_FFFF, 1);
    push_model(1'b0);
    csr_write(A_CTRL, 64'h1);
    tick();
    @(negedge clk_per);
    check("seed0_word0_top", uio_rq_data[W-1 -: 32], 32'h0000_000E);
    repeat (6) tick();
    csr_read(A_CTRL, 64'h03, ALL, "seed0_ctrl");

    // Mid-run reset for one cycle.
    lb_en = 1'b0;
    csr_write(A_TGT, 64'd0);
    model_gen(31'h7FFF_FFFF, 20);
    push_model(1'b0);
    csr_write(A_CTRL, 64'h1);
    repeat (5) tick();
    reset_per_n = 1'b0;
    tick();
    reset_per_n = 1'b1;
    @(negedge clk_per);
    check("midrst_rq_vld", uio_rq_vld, 0);
    check("midrst_rq_data", uio_rq_data, 0);
    exp_rq.delete();
    tick();
    csr_read(A_CTRL, 64'h0, ALL, "midrst_ctrl");
    csr_read(A_TX, 64'h0, ALL, "midrst_tx_cnt");
    csr_read(A_SEED, 64'h1, ALL, "midrst_seed");
    repeat (3) tick();
    check("rd_all_acked", exp_rd.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
